// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a registered-read FIFO and sends them
// as 8N1-style frames (start, WIDTH data bits LSB first, one stop bit).
module fifo_uart_tx #(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned WIDTH     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty_i,
   input  logic [WIDTH-1:0] fifo_data_i,
   output logic             fifo_rd_en_o,
   output logic             tx_o,
   output logic             busy_o
);

   localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);

   if (DIV < 2) begin : g_div_check
      $error("fifo_uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
   end

   if (WIDTH < 2) begin : g_width_check
      $error("fifo_uart_tx: WIDTH must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_LATCH = 3'd2,
      S_START = 3'd3,
      S_DATA  = 3'd4,
      S_STOP  = 3'd5
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nxt;
   logic             tx_r;
   logic             rd_en_r;
   logic             busy_r;
   logic             bit_end;

   assign shift_nxt = shift_r >> 1'b1;
   assign bit_end   = (cnt_r == CNT_LAST);

   // Outputs are loaded together with the state they belong to, so every
   // output is a flop that lines up exactly with state_r.
   // Frame sequencer, baud counter and shift register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= IDX_ZERO;
         shift_r <= '0;
         tx_r    <= 1'b1;
         rd_en_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               cnt_r <= CNT_ZERO;
               tx_r  <= 1'b1;
               if (!fifo_empty_i) begin
                  state_r <= S_POP;
                  rd_en_r <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= S_IDLE;
                  rd_en_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end

            S_POP: begin
               state_r <= S_LATCH;
               cnt_r   <= CNT_ZERO;
               tx_r    <= 1'b1;
               rd_en_r <= 1'b0;
               busy_r  <= 1'b1;
            end

            // FIFO read data is valid this cycle, one cycle after the strobe.
            S_LATCH: begin
               state_r <= S_START;
               cnt_r   <= CNT_ZERO;
               idx_r   <= IDX_ZERO;
               shift_r <= fifo_data_i;
               tx_r    <= 1'b0;
               rd_en_r <= 1'b0;
               busy_r  <= 1'b1;
            end

            S_START: begin
               rd_en_r <= 1'b0;
               busy_r  <= 1'b1;
               if (bit_end) begin
                  state_r <= S_DATA;
                  cnt_r   <= CNT_ZERO;
                  tx_r    <= shift_r[0];
               end else begin
                  state_r <= S_START;
                  cnt_r   <= cnt_r + CNT_ONE;
                  tx_r    <= 1'b0;
               end
            end

            S_DATA: begin
               rd_en_r <= 1'b0;
               busy_r  <= 1'b1;
               if (bit_end) begin
                  cnt_r   <= CNT_ZERO;
                  shift_r <= shift_nxt;
                  idx_r   <= idx_r + IDX_ONE;
                  if (idx_r == IDX_LAST) begin
                     state_r <= S_STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     state_r <= S_DATA;
                     tx_r    <= shift_nxt[0];
                  end
               end else begin
                  state_r <= S_DATA;
                  cnt_r   <= cnt_r + CNT_ONE;
                  tx_r    <= shift_r[0];
               end
            end

            // The empty flag is only sampled on the final stop cycle so a
            // byte arriving mid-frame waits for the current frame to finish.
            S_STOP: begin
               tx_r <= 1'b1;
               if (bit_end) begin
                  cnt_r <= CNT_ZERO;
                  if (!fifo_empty_i) begin
                     state_r <= S_POP;
                     rd_en_r <= 1'b1;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= S_IDLE;
                     rd_en_r <= 1'b0;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  state_r <= S_STOP;
                  cnt_r   <= cnt_r + CNT_ONE;
                  rd_en_r <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end

            default: begin
               state_r <= S_IDLE;
               cnt_r   <= CNT_ZERO;
               idx_r   <= IDX_ZERO;
               shift_r <= '0;
               tx_r    <= 1'b1;
               rd_en_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_o         = tx_r;
   assign fifo_rd_en_o = rd_en_r;
   assign busy_o       = busy_r;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Parameter WIDTH, default 8, data bits per frame; also the width of the FIFO read port.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-007 fifo_data_i  input  WIDTH  upstream FIFO read data; registered, valid the cycle after a read strobe.
REQ-008 fifo_rd_en_o  output  1  FIFO read strobe; single-cycle pulse per byte.
REQ-009 tx_o  output  1  UART serial line; idle high.
REQ-010 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 DIV = CLK_FREQ / BAUD_RATE (integer division); each serial bit SHALL last exactly DIV clk cycles.
REQ-012 DIV < 2 SHALL fail elaboration.
REQ-013 The baud counter SHALL be $clog2(DIV) bits wide, count 0..DIV-1, and clear on every state entry.
REQ-014 States: IDLE, POP, LATCH, START, DATA, STOP.
REQ-015 IDLE: tx_o=1; go to POP on a cycle with fifo_empty_i=0; otherwise stay in IDLE.
REQ-016 POP: fifo_rd_en_o=1 for exactly this one cycle; go to LATCH unconditionally.
REQ-017 LATCH: capture fifo_data_i into the shift register and clear the bit index; go to START.
REQ-018 START: tx_o=0 for DIV cycles; then go to DATA.
REQ-019 DATA: tx_o = shift register bit 0, LSB first; each bit lasts DIV cycles.
REQ-020 DATA: at the end of each bit, shift right and increment the bit index; after bit WIDTH-1, go to STOP.
REQ-021 STOP: tx_o=1 for DIV cycles; then go to POP if fifo_empty_i=0, else to IDLE.
REQ-022 Back-to-back frames SHALL be separated by exactly 2 extra idle-high cycles (the POP and LATCH cycles).
REQ-023 fifo_rd_en_o SHALL be 0 in every state except POP, so the block never strobes an empty FIFO.
REQ-024 tx_o SHALL be registered and glitch-free; it changes only on state/bit boundaries.
REQ-025 Frame length SHALL be (WIDTH+2)*DIV cycles.
REQ-026 The start bit SHALL begin 2 cycles after the POP cycle.
REQ-027 fifo_empty_i SHALL be ignored in every state except IDLE and the last cycle of STOP.
REQ-028 busy_o SHALL be 1 in POP, LATCH, START, DATA and STOP, and 0 in IDLE.

Reset
REQ-029 While rst_n=0 at a clock edge, the following SHALL hold on the next cycle: state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, baud counter=0, bit index=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame: tx_o returns high the cycle after the reset edge and the in-flight byte is discarded.
REQ-031 After an aborted frame, no FIFO read SHALL be re-issued for the discarded byte.
REQ-032 The first POP after rst_n deasserts SHALL occur no earlier than one cycle after deassertion.

Verification (CLK_FREQ=10, BAUD_RATE=1, DIV=10, WIDTH=8; FIFO model with 1-cycle registered read)
REQ-033 Reset, FIFO empty for 50 cycles -> tx_o=1, fifo_rd_en_o=0 and busy_o=0 throughout.
REQ-034 Push 0xA5 -> one rd_en pulse, then 2 cycles later tx_o sends 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; busy_o drops after 100 frame cycles.
REQ-035 Push 0x00 and 0xFF together -> two frames with exactly 2 high cycles between the first stop bit and the second start bit; exactly 2 rd_en pulses.
REQ-036 Assert rst_n=0 during data bit 3 of 0x3C -> next cycle tx_o=1 and busy_o=0; after release with the FIFO empty, no further rd_en pulse.
REQ-037 FIFO goes non-empty during DATA of the current frame -> no rd_en until the last STOP cycle; the next frame follows with the 2-cycle gap.
REQ-038 Scoreboard check with a UART RX model on 256 random bytes -> bytes received in order; rd_en pulse count = 256; rd_en never asserted while fifo_empty_i=1.
